// File: rtl/input_debounce_step.sv
// Board input front end: 2-flop sync, tick-sampled debounce and press pulses for SW/BTN.
// Optional auto-repeat of button pulses when INPUT_DEBOUNCE_AUTOREPEAT_EN is defined.
module input_debounce_step #(
   parameter int unsigned NSW          = 16,
   parameter int unsigned NBTN         = 5,
   parameter int unsigned SAMPLE_DIV   = 250000,
   parameter int unsigned STABLE_N     = 4,
   parameter int unsigned STEP_IDX     = 0,
   parameter int unsigned REPEAT_DELAY = 200,
   parameter int unsigned REPEAT_RATE  = 40
) (
   input  logic            CLK100MHZ,
   input  logic            CPU_RESETN,
   input  logic [NSW-1:0]  SW,
   input  logic [NBTN-1:0] BTN,
   output logic [NSW-1:0]  sw_db,
   output logic [NBTN-1:0] btn_db,
   output logic [NBTN-1:0] btn_rise,
   output logic            step_pulse,
   output logic            sample_tick
);

   localparam int unsigned NIN   = NSW + NBTN;
   localparam int unsigned DIV_W = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;

   if (SAMPLE_DIV < 2 || STABLE_N < 2 || STEP_IDX >= NBTN ||
       REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_param_err
      $error("input_debounce_step: invalid parameter set");
   end

   logic [NIN-1:0]      raw;
   logic [NIN-1:0]      sync1_q, sync2_q;
   logic [NIN-1:0]      db_q, db_d;
   logic [STABLE_N-1:0] hist_q [NIN];
   logic [STABLE_N-1:0] hist_d [NIN];
   logic [DIV_W-1:0]    div_q, div_d;
   logic                tick;
   logic [NBTN-1:0]     btn_db_dly_q;
   logic [NBTN-1:0]     rise_q, rise_d;
   logic [NBTN-1:0]     rpt_hit;

   assign raw  = {BTN, SW};
   assign tick = (div_q == DIV_W'(SAMPLE_DIV - 1));

   // The debounced level is judged on the freshly shifted history, so it moves on the tick edge itself.
   always_comb begin
      div_d = tick ? '0 : div_q + DIV_W'(1);
      db_d  = db_q;
      for (int unsigned i = 0; i < NIN; i++) begin
         hist_d[i] = hist_q[i];
         if (tick) begin
            hist_d[i] = {hist_q[i][STABLE_N-2:0], sync2_q[i]};
            if (&hist_d[i]) begin
               db_d[i] = 1'b1;
            end else if (~|hist_d[i]) begin
               db_d[i] = 1'b0;
            end
         end
      end
   end

   assign rise_d = (db_q[NIN-1:NSW] & ~btn_db_dly_q) | rpt_hit;

`ifdef INPUT_DEBOUNCE_AUTOREPEAT_EN
   localparam int unsigned RPT_W = $clog2(REPEAT_DELAY + REPEAT_RATE + 1);

   logic [RPT_W-1:0] rpt_cnt_q [NBTN];
   logic [RPT_W-1:0] rpt_cnt_d [NBTN];

   // Counter folds back to REPEAT_DELAY after each period so repeats never run out.
   always_comb begin
      logic [RPT_W-1:0] nxt;
      nxt     = '0;
      rpt_hit = '0;
      for (int unsigned i = 0; i < NBTN; i++) begin
         rpt_cnt_d[i] = rpt_cnt_q[i];
         nxt          = rpt_cnt_q[i] + RPT_W'(1);
         if (!db_q[NSW+i]) begin
            rpt_cnt_d[i] = '0;
         end else if (tick) begin
            rpt_hit[i]   = (nxt == RPT_W'(REPEAT_DELAY)) ||
                           (nxt == RPT_W'(REPEAT_DELAY + REPEAT_RATE));
            rpt_cnt_d[i] = (nxt == RPT_W'(REPEAT_DELAY + REPEAT_RATE)) ?
                           RPT_W'(REPEAT_DELAY) : nxt;
         end
      end
   end

   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         for (int unsigned i = 0; i < NBTN; i++) rpt_cnt_q[i] <= '0;
      end else begin
         for (int unsigned i = 0; i < NBTN; i++) rpt_cnt_q[i] <= rpt_cnt_d[i];
      end
   end
`else
   assign rpt_hit = '0;
`endif

   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         sync1_q      <= '0;
         sync2_q      <= '0;
         db_q         <= '0;
         div_q        <= '0;
         btn_db_dly_q <= '0;
         rise_q       <= '0;
         for (int unsigned i = 0; i < NIN; i++) hist_q[i] <= '0;
      end else begin
         sync1_q      <= raw;
         sync2_q      <= sync1_q;
         db_q         <= db_d;
         div_q        <= div_d;
         btn_db_dly_q <= db_q[NIN-1:NSW];
         rise_q       <= rise_d;
         for (int unsigned i = 0; i < NIN; i++) hist_q[i] <= hist_d[i];
      end
   end

   assign sw_db       = db_q[NSW-1:0];
   assign btn_db      = db_q[NIN-1:NSW];
   assign btn_rise    = rise_q;
   assign step_pulse  = rise_q[STEP_IDX];
   assign sample_tick = tick;

endmodule

// File: tb/tb_input_debounce_step.sv
// Directed bench for input_debounce_step with SAMPLE_DIV=4, STABLE_N=3.
module tb_input_debounce_step;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] sw = '0;
   logic [4:0]  btn = '0;
   logic [15:0] sw_db;
   logic [4:0]  btn_db;
   logic [4:0]  btn_rise;
   logic        step_pulse;
   logic        sample_tick;

   always #5 clk = ~clk;

   input_debounce_step #(
      .NSW(16), .NBTN(5), .SAMPLE_DIV(4), .STABLE_N(3), .STEP_IDX(0),
      .REPEAT_DELAY(5), .REPEAT_RATE(2)
   ) dut (
      .CLK100MHZ(clk), .CPU_RESETN(rst_n), .SW(sw), .BTN(btn),
      .sw_db(sw_db), .btn_db(btn_db), .btn_rise(btn_rise),
      .step_pulse(step_pulse), .sample_tick(sample_tick)
   );

   typedef struct {
      logic [15:0] sw;
      logic [4:0]  btn;
      logic [15:0] exp_sw;
      logic [4:0]  exp_btn;
      int          exp_rises;
      int          exp_steps;
   } vec_t;

   int total = 0;
   int bad   = 0;
   int rise_cnt [5];
   int run      [5];
   int maxrun   [5];
   int step_cnt;
   int tick_cnt;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic clr();
      for (int i = 0; i < 5; i++) begin
         rise_cnt[i] = 0; run[i] = 0; maxrun[i] = 0;
      end
      step_cnt = 0;
      tick_cnt = 0;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
      for (int i = 0; i < 5; i++) begin
         if (btn_rise[i]) begin
            rise_cnt[i]++;
            run[i]++;
            if (run[i] > maxrun[i]) maxrun[i] = run[i];
         end else begin
            run[i] = 0;
         end
      end
      if (step_pulse) step_cnt++;
      if (sample_tick) tick_cnt++;
   endtask

   function automatic int sum_rise();
      int s = 0;
      for (int i = 0; i < 5; i++) s += rise_cnt[i];
      return s;
   endfunction

   vec_t vecs [6];
   int   lat;
   bit   seen, fell, ever;
   int   exp_rep;

   initial begin
      vecs[0] = '{16'hA5A5, 5'b00000, 16'hA5A5, 5'b00000, 0, 0};
      vecs[1] = '{16'hFFFF, 5'b10110, 16'hFFFF, 5'b10110, 3, 0};
      vecs[2] = '{16'h0000, 5'b10110, 16'h0000, 5'b10110, 0, 0};
      vecs[3] = '{16'h1234, 5'b01001, 16'h1234, 5'b01001, 2, 1};
      vecs[4] = '{16'h1234, 5'b11111, 16'h1234, 5'b11111, 3, 0};
      vecs[5] = '{16'h0000, 5'b00000, 16'h0000, 5'b00000, 0, 0};
      clr();

      // Reset state with active inputs
      sw = 16'hFFFF; btn = 5'b11111;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_sw_db", 32'(sw_db), 32'h0);
      chk("rst_btn_db", 32'(btn_db), 32'h0);
      chk("rst_btn_rise", 32'(btn_rise), 32'h0);
      chk("rst_step", 32'(step_pulse), 32'h0);
      chk("rst_tick", 32'(sample_tick), 32'h0);
      sw = '0; btn = '0;
      rst_n = 1'b1;
      repeat (20) cyc();

      // 1: clean press on step button
      clr();
      btn[0] = 1'b1;
      lat = 0; seen = 0;
      for (int k = 0; k < 40 && !seen; k++) begin
         cyc(); lat++;
         if (btn_db[0]) seen = 1;
      end
      chk("t1_db_seen", 32'(seen), 32'h1);
      chk("t1_latency_ok", 32'(lat >= 9 && lat <= 15), 32'h1);
      repeat (3) cyc();
      chk("t1_rise_cnt", 32'(rise_cnt[0]), 32'd1);
      chk("t1_step_cnt", 32'(step_cnt), 32'd1);
      chk("t1_pulse_width", 32'(maxrun[0]), 32'd1);
      repeat (40 - lat - 3) cyc();
      btn[0] = 1'b0;
      repeat (20) cyc();
      chk("t1_release_db", 32'(btn_db[0]), 32'h0);
      chk("t1_no_release_pulse", 32'(rise_cnt[0]), 32'd1);

      // 2: bounce then hold
      clr();
      for (int k = 0; k < 10; k++) begin
         btn[1] = ~btn[1];
         repeat (3) cyc();
      end
      chk("t2_bounce_no_rise", 32'(rise_cnt[1]), 32'd0);
      btn[1] = 1'b1;
      seen = 0; fell = 0;
      for (int k = 0; k < 40; k++) begin
         cyc();
         if (btn_db[1]) seen = 1;
         else if (seen) fell = 1;
      end
      chk("t2_db_high", 32'(btn_db[1]), 32'h1);
      chk("t2_never_fell", 32'(fell), 32'h0);
      chk("t2_one_rise", 32'(rise_cnt[1]), 32'd1);
      btn[1] = 1'b0;
      repeat (20) cyc();

      // 3: glitch straddling one tick
      clr();
      seen = 0;
      for (int k = 0; k < 10 && !seen; k++) begin
         cyc();
         if (sample_tick) seen = 1;
      end
      chk("t3_tick_found", 32'(seen), 32'h1);
      cyc();
      btn[2] = 1'b1;
      ever = 0;
      for (int k = 0; k < 5; k++) begin
         cyc();
         if (btn_db[2]) ever = 1;
      end
      btn[2] = 1'b0;
      for (int k = 0; k < 20; k++) begin
         cyc();
         if (btn_db[2]) ever = 1;
      end
      chk("t3_db_stays_0", 32'(ever), 32'h0);
      chk("t3_no_rise", 32'(rise_cnt[2]), 32'd0);

      // 4: switches
      clr();
      sw = 16'hA5A5;
      lat = 0; seen = 0;
      for (int k = 0; k < 40 && !seen; k++) begin
         cyc(); lat++;
         if (sw_db == 16'hA5A5) seen = 1;
      end
      chk("t4_sw_seen", 32'(seen), 32'h1);
      chk("t4_latency_ok", 32'(lat <= 15), 32'h1);
      repeat (5) cyc();
      chk("t4_sw_db", 32'(sw_db), 32'hA5A5);
      chk("t4_no_btn_rise", 32'(sum_rise()), 32'd0);

      // 5: reset mid-debounce
      clr();
      btn[3] = 1'b1;
      for (int k = 0; k < 20 && tick_cnt < 2; k++) cyc();
      chk("t5_two_ticks", 32'(tick_cnt), 32'd2);
      rst_n = 1'b0;
      #1;
      chk("t5_rst_sw_db", 32'(sw_db), 32'h0);
      chk("t5_rst_btn_db", 32'(btn_db), 32'h0);
      chk("t5_rst_rise", 32'(btn_rise), 32'h0);
      chk("t5_rst_tick", 32'(sample_tick), 32'h0);
      repeat (3) cyc();
      rst_n = 1'b1;
      clr();
      seen = 0;
      for (int k = 0; k < 40 && !seen; k++) begin
         cyc();
         if (btn_db[3]) seen = 1;
      end
      chk("t5_db_seen", 32'(seen), 32'h1);
      chk("t5_fresh_ticks", 32'(tick_cnt), 32'd3);
      repeat (3) cyc();
      chk("t5_one_rise", 32'(rise_cnt[3]), 32'd1);

      // Table of steady input sets
      foreach (vecs[v]) begin
         clr();
         sw  = vecs[v].sw;
         btn = vecs[v].btn;
         repeat (16) cyc();
         chk($sformatf("vec%0d_sw_db", v), 32'(sw_db), 32'(vecs[v].exp_sw));
         chk($sformatf("vec%0d_btn_db", v), 32'(btn_db), 32'(vecs[v].exp_btn));
         chk($sformatf("vec%0d_rises", v), 32'(sum_rise()), 32'(vecs[v].exp_rises));
         chk($sformatf("vec%0d_steps", v), 32'(step_cnt), 32'(vecs[v].exp_steps));
      end
      repeat (10) cyc();

      // 6: long hold, repeat behaviour depends on build
`ifdef INPUT_DEBOUNCE_AUTOREPEAT_EN
      exp_rep = 9;
`else
      exp_rep = 1;
`endif
      clr();
      btn[0] = 1'b1;
      seen = 0;
      for (int k = 0; k < 40 && !seen; k++) begin
         cyc();
         if (btn_db[0]) seen = 1;
      end
      chk("t6_db_seen", 32'(seen), 32'h1);
      tick_cnt = 0;
      for (int k = 0; k < 200 && tick_cnt < 20; k++) cyc();
      chk("t6_ticks", 32'(tick_cnt), 32'd20);
      cyc();
      chk("t6_pulses", 32'(rise_cnt[0]), 32'(exp_rep));
      chk("t6_pulse_width", 32'(maxrun[0]), 32'd1);
      btn[0] = 1'b0;
      repeat (20) cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
